// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: byte width, ASCII line feed
// and the 2-bit state encoding used by uart_tx_arbiter.
// Optional line lock feature is enabled by defining UART_ARB_LINE_LOCK_EN.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

endpackage : uart_arb_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of mask
// strictly after index last, wrapping around; found is low for an empty mask.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win,
  output logic             found
);

  // Scan offsets 1..N_REQ from last; the earliest hit wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!found && mask[IDX_W'((32'(last) + k) % N_REQ)]) begin
        found = 1'b1;
        win   = IDX_W'((32'(last) + k) % N_REQ);
      end
    end
  end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte
// producers. Each grant issues a one-cycle send pulse, then the arbiter waits
// for the transmitter to go busy and return idle before the next decision.
// Define UART_ARB_LINE_LOCK_EN to keep the grant on one producer until it
// sends a line feed (with optional LOCK_TIMEOUT release).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    tx_ready,
  output logic                    tx_send,
  output logic [BYTE_W-1:0]       tx_data,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              tx_send_d;
  logic [N_REQ-1:0]  req_ready_d;
  logic [N_REQ-1:0]  grant_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic              busy_d;

  logic [N_REQ-1:0]  elig_c;
  logic [IDX_W-1:0]  win_c;
  logic              found_c;
  logic [BYTE_W-1:0] win_data_c;
  logic [N_REQ-1:0]  win_onehot_c;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .mask  (elig_c),
    .last  (last_q),
    .win   (win_c),
    .found (found_c)
  );

  // Select the winner's byte from the flattened data bus
  always_comb begin
    win_data_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_c == IDX_W'(i)) begin
        win_data_c = req_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // One-hot form of the winner index
  always_comb win_onehot_c = N_REQ'(1) << win_c;

`ifdef UART_ARB_LINE_LOCK_EN
  localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // While locked only the lock owner may be picked
  always_comb elig_c = lock_q ? (req_valid & (N_REQ'(1) << lock_id_q)) : req_valid;

  // Lock set on non-LF grants, cleared by LF or by the idle timeout
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
    if (state_q == ST_IDLE) begin
      if (tx_ready && found_c) begin
        cnt_d = '0;
        if (win_data_c == ASCII_LF) begin
          lock_d = 1'b0;
        end else begin
          lock_d    = 1'b1;
          lock_id_d = win_c;
        end
      end else if ((LOCK_TIMEOUT != 0) && lock_q && !req_valid[lock_id_q]) begin
        if (32'(cnt_q) + 32'd1 >= LOCK_TIMEOUT) begin
          lock_d = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Lock state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      cnt_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  logic unused_lock_timeout;

  // Plain per-byte round robin: every valid requester is eligible
  always_comb elig_c = req_valid;

  assign unused_lock_timeout = (LOCK_TIMEOUT != 0);
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    tx_send_d   = 1'b0;
    req_ready_d = '0;
    grant_d     = grant;
    tx_data_d   = tx_data;
    case (state_q)
      ST_IDLE: begin
        if (tx_ready && found_c) begin
          state_d     = ST_SEND;
          tx_send_d   = 1'b1;
          req_ready_d = win_onehot_c;
          grant_d     = win_onehot_c;
          tx_data_d   = win_data_c;
          last_d      = win_c;
        end
      end
      ST_SEND:      state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_ready) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (tx_ready)  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_q    <= IDX_W'(N_REQ - 1);
      tx_send   <= 1'b0;
      req_ready <= '0;
      grant     <= '0;
      tx_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tx_send   <= tx_send_d;
      req_ready <= req_ready_d;
      grant     <= grant_d;
      tx_data   <= tx_data_d;
      busy      <= busy_d;
    end
  end

endmodule : uart_tx_arbiter
